// File: rtl/disp_pkg.sv
// Shared constants, FSM encoding and the captured-slot record for the display scan formatter.
package disp_pkg;

    localparam int ENTRY_CHARS = 14;
    localparam int NAME_CHARS  = 5;
    localparam int HEX_DIGITS  = 8;

    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] COLON = 8'h3A;

    typedef logic [2:0] state_t;

    localparam state_t ST_REQ     = 3'd0;
    localparam state_t ST_WAIT    = 3'd1;
    localparam state_t ST_CAPTURE = 3'd2;
    localparam state_t ST_EMIT    = 3'd3;
    localparam state_t ST_GAP     = 3'd4;

    typedef struct packed {
        logic        valid;
        logic [39:0] name;
        logic [31:0] value;
    } entry_t;

    // Unused name bytes arrive as 0x00 and must print as blanks.
    function automatic logic [7:0] name_char(input logic [7:0] b);
        return (b == 8'h00) ? SPACE : b;
    endfunction

endpackage

// File: rtl/disp_hex_ascii.sv
// Combinational 4-bit nibble to uppercase ASCII hex digit.
module disp_hex_ascii (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble < 4'd10) begin
            ascii = 8'h30 + {4'h0, nibble};
        end else begin
            ascii = 8'h37 + {4'h0, nibble};
        end
    end

endmodule

// File: rtl/display_scan_formatter.sv
// Scans responder slots 1..NUM_ENTRIES and streams each as a 14-char ASCII line.
// Optional macro DISP_SKIP_INVALID_EN: unpopulated slots emit no characters.
module display_scan_formatter
    import disp_pkg::*;
#(
    parameter int NUM_ENTRIES = 44,
    parameter int FRAME_GAP   = 1000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [5:0]  display_number,
    input  logic        display_valid,
    input  logic [39:0] display_name,
    input  logic [31:0] display_value,
    output logic        char_valid,
    input  logic        char_ready,
    output logic [7:0]  char_data,
    output logic [5:0]  char_row,
    output logic [3:0]  char_col,
    output logic        frame_done
);

    localparam logic [5:0] LAST_SLOT = 6'(NUM_ENTRIES);
    localparam logic [3:0] LAST_COL  = 4'(ENTRY_CHARS - 1);
    localparam logic [3:0] COLON_COL = 4'(NAME_CHARS);
    localparam int         GAP_W     = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);

    state_t           state;
    logic [5:0]       slot;
    logic [GAP_W-1:0] gap_cnt;
    entry_t           entry_q;
    entry_t           sel_entry;
    logic [3:0]       sel_col;
    logic [7:0]       name_byte;
    logic [3:0]       nibble;
    logic [7:0]       hex_char;
    logic [7:0]       next_char;
    logic             capture_emits;
    logic             line_end;

`ifdef DISP_SKIP_INVALID_EN
    assign capture_emits = display_valid;
`else
    assign capture_emits = 1'b1;
`endif

    assign line_end = ((state == ST_EMIT) && char_ready && (char_col == LAST_COL))
                   || ((state == ST_CAPTURE) && !capture_emits);

    // The character presented next is built either from the responder bus (col 0,
    // during capture) or from the latched entry (the column after the current one).
    always_comb begin
        sel_entry = entry_q;
        sel_col   = char_col + 4'd1;
        if (state == ST_CAPTURE) begin
            sel_entry.valid = display_valid;
            sel_entry.name  = display_name;
            sel_entry.value = display_value;
            sel_col         = 4'd0;
        end
    end

    always_comb begin
        name_byte = 8'h00;
        nibble    = 4'h0;
        case (sel_col)
            4'd0:    name_byte = sel_entry.name[39:32];
            4'd1:    name_byte = sel_entry.name[31:24];
            4'd2:    name_byte = sel_entry.name[23:16];
            4'd3:    name_byte = sel_entry.name[15:8];
            4'd4:    name_byte = sel_entry.name[7:0];
            4'd6:    nibble    = sel_entry.value[31:28];
            4'd7:    nibble    = sel_entry.value[27:24];
            4'd8:    nibble    = sel_entry.value[23:20];
            4'd9:    nibble    = sel_entry.value[19:16];
            4'd10:   nibble    = sel_entry.value[15:12];
            4'd11:   nibble    = sel_entry.value[11:8];
            4'd12:   nibble    = sel_entry.value[7:4];
            4'd13:   nibble    = sel_entry.value[3:0];
            default: ;
        endcase
    end

    disp_hex_ascii u_hex (
        .nibble (nibble),
        .ascii  (hex_char)
    );

    always_comb begin
        next_char = SPACE;
        if (sel_entry.valid) begin
            if (sel_col < COLON_COL) begin
                next_char = name_char(name_byte);
            end else if (sel_col == COLON_COL) begin
                next_char = COLON;
            end else begin
                next_char = hex_char;
            end
        end
    end

    // Main scan FSM; the end-of-line decision at the bottom overrides the per-state
    // next state so EMIT and a skipped CAPTURE share one slot-advance path.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_REQ;
            slot           <= 6'd1;
            gap_cnt        <= '0;
            entry_q        <= '0;
            display_number <= 6'd0;
            char_valid     <= 1'b0;
            char_data      <= 8'h00;
            char_row       <= 6'd0;
            char_col       <= 4'd0;
            frame_done     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_REQ: begin
                    display_number <= slot;
                    state          <= ST_WAIT;
                end
                ST_WAIT: begin
                    state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    entry_q <= sel_entry;
                    if (capture_emits) begin
                        char_valid <= 1'b1;
                        char_data  <= next_char;
                        char_row   <= slot;
                        char_col   <= 4'd0;
                        state      <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (char_ready) begin
                        if (char_col == LAST_COL) begin
                            char_valid <= 1'b0;
                        end else begin
                            char_col  <= char_col + 4'd1;
                            char_data <= next_char;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        slot    <= 6'd1;
                        state   <= ST_REQ;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    state <= ST_REQ;
                end
            endcase

            if (line_end) begin
                if (slot == LAST_SLOT) begin
                    frame_done <= 1'b1;
                    if (FRAME_GAP == 0) begin
                        slot  <= 6'd1;
                        state <= ST_REQ;
                    end else begin
                        state <= ST_GAP;
                    end
                end else begin
                    slot  <= slot + 6'd1;
                    state <= ST_REQ;
                end
            end
        end
    end

endmodule

// File: tb/tb_display_scan_formatter.sv
// Randomized bench for display_scan_formatter with a registered responder and a line-level reference model.
module tb_display_scan_formatter;

    localparam int NUM_ENTRIES = 4;
    localparam int FRAME_GAP   = 5;
    localparam int NUM_FRAMES  = 8;
    localparam int MAX_CYCLES  = 20000;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  display_number;
    logic        display_valid;
    logic [39:0] display_name;
    logic [31:0] display_value;
    logic        char_valid;
    logic        char_ready;
    logic [7:0]  char_data;
    logic [5:0]  char_row;
    logic [3:0]  char_col;
    logic        frame_done;

    int tests_run    = 0;
    int tests_failed = 0;

    logic        tbl_valid [0:63];
    logic [39:0] tbl_name  [0:63];
    logic [31:0] tbl_value [0:63];

    typedef struct {
        logic [5:0] row;
        logic [3:0] col;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   exp_count;

    display_scan_formatter #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .FRAME_GAP   (FRAME_GAP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .display_number (display_number),
        .display_valid  (display_valid),
        .display_name   (display_name),
        .display_value  (display_value),
        .char_valid     (char_valid),
        .char_ready     (char_ready),
        .char_data      (char_data),
        .char_row       (char_row),
        .char_col       (char_col),
        .frame_done     (frame_done)
    );

    always #5 clk = ~clk;

    // Responder with one cycle of registered latency; slot 0 is never populated.
    always_ff @(posedge clk) begin
        display_valid <= tbl_valid[display_number];
        display_name  <= tbl_name[display_number];
        display_value <= tbl_value[display_number];
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [7:0] ref_char(input logic v, input logic [39:0] nm, input logic [31:0] val, input int c);
        logic [39:0] nsh;
        logic [31:0] vsh;
        int          n;
        if (!v) return 8'h20;
        if (c < 5) begin
            nsh = nm >> (8 * (4 - c));
            return (nsh[7:0] == 8'h00) ? 8'h20 : nsh[7:0];
        end
        if (c == 5) return 8'h3A;
        vsh = val >> (4 * (13 - c));
        n   = int'(vsh[3:0]);
        return (n < 10) ? 8'(48 + n) : 8'(55 + n);
    endfunction

    task automatic build_frame();
        exp_t e;
        exp_q.delete();
        for (int s = 1; s <= NUM_ENTRIES; s++) begin
`ifdef DISP_SKIP_INVALID_EN
            if (!tbl_valid[s]) continue;
`endif
            for (int c = 0; c < 14; c++) begin
                e.row  = 6'(s);
                e.col  = 4'(c);
                e.data = ref_char(tbl_valid[s], tbl_name[s], tbl_value[s], c);
                exp_q.push_back(e);
            end
        end
        exp_count = exp_q.size();
    endtask

    task automatic applyStimulus(input int frame);
        logic [7:0] b;
        for (int s = 1; s <= NUM_ENTRIES; s++) begin
            tbl_valid[s] = ($urandom_range(0, 3) != 0);
            tbl_value[s] = $urandom;
            for (int k = 0; k < 5; k++) begin
                b = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(32, 126));
                tbl_name[s] = {tbl_name[s][31:0], b};
            end
        end
        if (frame == 0) begin
            for (int s = 1; s <= NUM_ENTRIES; s++) tbl_valid[s] = 1'b0;
            tbl_valid[3] = 1'b1;
            tbl_name[3]  = 40'h524553554C;
            tbl_value[3] = 32'h0;
        end else if (frame == 1) begin
            tbl_valid[1] = 1'b1;
            tbl_name[1]  = 40'h4144445F31;
            tbl_value[1] = 32'h1234ABCD;
            tbl_valid[2] = 1'b1;
            tbl_name[2]  = 40'h0000004142;
            tbl_value[2] = 32'hFFFFFFFF;
            tbl_valid[4] = 1'b0;
        end else if (frame == 2) begin
            tbl_valid[2] = 1'b1;
        end
    endtask

    initial begin
        int         frame_idx   = 0;
        int         chars       = 0;
        int         idle        = 0;
        bit         measuring   = 0;
        bit         stalled     = 0;
        bit         expect_next = 0;
        bit         prev_done   = 0;
        bit         in_reset    = 0;
        bit         reset_done  = 0;
        bit         mutated     = 0;
        logic [3:0] next_col    = 4'd0;
        logic [17:0] held       = '0;
        exp_t       e;

        for (int s = 0; s < 64; s++) begin
            tbl_valid[s] = 1'b0;
            tbl_name[s]  = '0;
            tbl_value[s] = '0;
        end
        reset      = 1'b1;
        char_ready = 1'b0;
        applyStimulus(0);
        repeat (3) @(negedge clk);
        checkOutput("rst_number", display_number, 0);
        checkOutput("rst_valid", char_valid, 0);
        checkOutput("rst_data", char_data, 0);
        checkOutput("rst_row", char_row, 0);
        checkOutput("rst_col", char_col, 0);
        checkOutput("rst_done", frame_done, 0);
        reset = 1'b0;
        build_frame();

        for (int cyc = 0; cyc < MAX_CYCLES && frame_idx < NUM_FRAMES; cyc++) begin
            @(negedge clk);
            char_ready = (frame_idx < 2) ? 1'b1 : ($urandom_range(0, 99) < 60);

            if (in_reset) begin
                checkOutput("abort_valid", char_valid, 0);
                checkOutput("abort_number", display_number, 0);
                checkOutput("abort_done", frame_done, 0);
                reset       = 1'b0;
                in_reset    = 0;
                build_frame();
                chars       = 0;
                measuring   = 0;
                stalled     = 0;
                expect_next = 0;
                prev_done   = 0;
                continue;
            end

            if (stalled) begin
                checkOutput("hold_valid", char_valid, 1);
                checkOutput("hold_fields", {char_row, char_col, char_data}, held);
            end
            if (expect_next) begin
                checkOutput("next_valid", char_valid, 1);
                checkOutput("next_col", char_col, next_col);
            end
            if (prev_done) checkOutput("done_width", frame_done, 0);
            if (char_valid) checkOutput("number_row", display_number, char_row);

            if (measuring) begin
                if (char_valid) begin
`ifdef DISP_SKIP_INVALID_EN
                    checkOutput("gap_min", (idle >= FRAME_GAP + 3), 1);
`else
                    checkOutput("gap_len", idle, FRAME_GAP + 3);
`endif
                    measuring = 0;
                end else begin
                    idle++;
                end
            end

            if (frame_done) begin
                checkOutput("frame_left", exp_q.size(), 0);
                checkOutput("frame_chars", chars, exp_count);
                frame_idx++;
                applyStimulus(frame_idx);
                build_frame();
                chars     = 0;
                measuring = 1;
                idle      = 1;
            end

            if (frame_idx == 1 && !mutated && char_valid && char_row == 6'd2 && char_col == 4'd0) begin
                tbl_value[2] = 32'h0;
                mutated      = 1;
            end

            if (frame_idx == 2 && !reset_done && char_valid && char_row == 6'd2 && char_col == 4'd7) begin
                reset       = 1'b1;
                char_ready  = 1'b0;
                reset_done  = 1;
                in_reset    = 1;
                stalled     = 0;
                expect_next = 0;
                prev_done   = 0;
                continue;
            end

            prev_done   = frame_done;
            stalled     = char_valid && !char_ready;
            held        = {char_row, char_col, char_data};
            expect_next = 0;
            if (char_valid && char_ready) begin
                chars++;
                if (exp_q.size() == 0) begin
                    checkOutput("extra_char", {char_row, char_col, char_data}, 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("char_row", char_row, e.row);
                    checkOutput("char_col", char_col, e.col);
                    checkOutput("char_data", char_data, e.data);
                end
                if (char_col != 4'd13) begin
                    expect_next = 1;
                    next_col    = char_col + 4'd1;
                end
            end
        end

        if (frame_idx < NUM_FRAMES) checkOutput("timeout_frames", frame_idx, NUM_FRAMES);
        checkOutput("reset_test_hit", reset_done, 1);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/display_scan_formatter.md
Name: display_scan_formatter

Overview:
- Sits between the per-lab display responder and the LCD text writer.
- Owns the `display_number` scan: steps through display slots 1..NUM_ENTRIES and samples the responder's registered `display_valid` / `display_name` / `display_value`.
- Formats each slot as a 14-character ASCII line: 5 name chars, `:`, 8 uppercase hex digits.
- Streams characters downstream over a valid/ready handshake; repeats the frame forever.

Parameters:
- NUM_ENTRIES, 44: number of display slots scanned per frame, max 63.
- FRAME_GAP, 1000: idle clk cycles between frames; 0 is legal (no gap).

Ports:
- clk  in  1  system clock (10 MHz board clock).
- reset  in  1  synchronous, active-high reset.
- display_number  out  6  slot currently requested from the responder.
- display_valid  in  1  responder: slot populated.
- display_name  in  40  responder: 5 ASCII chars, first char in [39:32].
- display_value  in  32  responder: value to show.
- char_valid  out  1  character available.
- char_ready  in  1  downstream accepts character.
- char_data  out  8  ASCII code.
- char_row  out  6  slot index of `char_data`, 1..NUM_ENTRIES.
- char_col  out  4  column 0..13.
- frame_done  out  1  one-cycle pulse after the last character of a frame is accepted.

Behaviour:
- Reset state (registered): display_number=0, char_valid=0, char_data=0, char_row=0, char_col=0, frame_done=0, FSM=REQ, slot counter=1.
- Slot 0 is never a valid slot, so the responder reports invalid during reset.
- Reset asserted mid-frame or mid-handshake aborts immediately. The next frame starts at slot 1.
- FSM states: REQ, WAIT, CAPTURE, EMIT, GAP.
  - REQ: drive display_number=slot; go to WAIT.
  - WAIT: one cycle, because the responder output is registered; go to CAPTURE.
  - CAPTURE: latch valid/name/value into local registers; go to EMIT.
    - Request-to-capture latency is 2 clk edges.
    - display_number stays stable from REQ until the slot leaves EMIT.
  - EMIT: present 14 characters in order, col 0..13, row=slot.
    - char_valid and char_data/row/col stay stable until char_ready=1.
    - A transfer occurs on a cycle with char_valid & char_ready. The next char is presented the following cycle, so at most one char per cycle.
    - After col 13 transfers: if slot==NUM_ENTRIES, pulse frame_done and go to GAP; else increment slot and go to REQ.
  - GAP: count FRAME_GAP cycles with char_valid=0; then slot=1 and go to REQ. With FRAME_GAP=0, go straight to REQ.
- Character mapping, valid slot:
  - Cols 0-4 come from name bytes [39:32]..[7:0]; byte 0x00 maps to 0x20 (space).
  - Col 5 is 0x3A (`:`).
  - Cols 6-13 are hex nibbles value[31:28]..[3:0]: 0-9 map to 0x30-0x39, A-F map to 0x41-0x46.
- Invalid slot: all 14 chars are 0x20, which clears stale text.
- Responder inputs changing after CAPTURE do not affect the line being emitted.
- char_ready high while char_valid=0 has no effect.
- char_ready held low stalls indefinitely with no loss.

Optional Feature:
- Macro DISP_SKIP_INVALID_EN.
- Defined: an invalid slot emits nothing. CAPTURE goes directly to the next-slot decision (frame_done still fires if it is the last slot). A frame with no valid slots emits 0 chars but still pulses frame_done.
- Undefined: invalid slots emit 14 spaces as above.

Decomposition:
- Package disp_pkg holds:
  - FSM state encoding.
  - ENTRY_CHARS=14, NAME_CHARS=5, HEX_DIGITS=8.
  - ASCII constants SPACE=0x20, COLON=0x3A.
- Sub-module disp_hex_ascii: combinational 4-bit nibble to 8-bit uppercase ASCII; one instance, nibble selected by char_col.

Test Plan:
1. Slot 1 valid, name "ADD_1", value 0x1234ABCD, char_ready=1 → row 1 emits "ADD_1:1234ABCD" over 14 consecutive cycles, cols 0..13.
2. Slot 3 name "RESUL", value 0 (operands 0), others invalid, NUM_ENTRIES=4, FRAME_GAP=5:
   - Without the macro: 56 chars, row 3 = "RESUL:00000000", other rows 14 spaces; frame_done pulses once; 5 idle cycles; display_number returns to 1.
   - With DISP_SKIP_INVALID_EN: exactly 14 chars, all row 3.
3. Name 0x0000004142 ("AB" right-aligned) → cols 0-2 are spaces, cols 3-4 are "AB".
4. char_ready toggles 1,0,0,1 during EMIT → char_data/row/col held while ready=0; no char duplicated or dropped; display_number constant.
5. Responder value changed from 0xFFFFFFFF to 0 one cycle after CAPTURE → line still shows "FFFFFFFF".
6. Reset pulsed at col 7 of slot 2 → next cycle: char_valid=0, display_number=0, frame_done=0; after release the first emitted char is row 1, col 0.
